// File: rtl/apx_mon_pkg.sv
// Shared constants and helpers for the approximate-adder error monitor.
// Optional feature macro: APXMON_BITFLIP_EN (per-output-bit flip counters).
package apx_mon_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   function automatic int unsigned vec_w(input int unsigned in_w);
      return 2 * in_w;
   endfunction

   function automatic int unsigned sum_w(input int unsigned in_w, input int unsigned out_w);
      return out_w + 2 * in_w;
   endfunction

   function automatic int unsigned cnt_w(input int unsigned in_w);
      return 2 * in_w + 1;
   endfunction

   // Exact a + b for a stimulus vector packed as {b, a}, each in_w bits wide.
   function automatic logic [31:0] exact_sum(input logic [31:0] vec, input int unsigned in_w);
      logic [31:0] mask;
      mask = (32'd1 << in_w) - 32'd1;
      return (vec & mask) + ((vec >> in_w) & mask);
   endfunction

endpackage

// File: rtl/apx_mon_delay.sv
// Valid + data shift line of DEPTH registers, used to align stimulus with AUT output.
// Optional feature macro: APXMON_BITFLIP_EN (not used in this file).
module apx_mon_delay #(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned W     = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   output logic [W-1:0] out_data
);

   logic [DEPTH-1:0]         vld;
   logic [DEPTH-1:0][W-1:0]  dat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
         dat <= '0;
      end else begin
         vld[0] <= in_valid;
         dat[0] <= in_data;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            vld[i] <= vld[i-1];
            dat[i] <= dat[i-1];
         end
      end
   end

   assign out_valid = vld[DEPTH-1];
   assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/apx_adder_err_monitor.sv
// Exhaustive sweep driver and error-metric accumulator for an approximate adder under test.
// Optional feature macro: APXMON_BITFLIP_EN adds bit_flip_cnt (one flip counter per output bit).
module apx_adder_err_monitor
   import apx_mon_pkg::*;
#(
   parameter int unsigned IN_W    = 2,
   parameter int unsigned OUT_W   = IN_W + 1,
   parameter int unsigned ET      = 5,
   parameter int unsigned DUT_LAT = 0
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   output logic [vec_w(IN_W)-1:0]          dut_in,
   input  logic [OUT_W-1:0]                dut_out,
   output logic                            busy,
   output logic                            done,
   output logic                            pass,
   output logic [OUT_W-1:0]                max_err,
   output logic [sum_w(IN_W, OUT_W)-1:0]   err_sum,
   output logic [cnt_w(IN_W)-1:0]          viol_cnt,
   output logic [vec_w(IN_W)-1:0]          first_viol_vec,
   output logic                            first_viol_valid
`ifdef APXMON_BITFLIP_EN
   ,
   output logic [OUT_W*cnt_w(IN_W)-1:0]    bit_flip_cnt
`endif
);

   localparam int unsigned VW = vec_w(IN_W);
   localparam int unsigned SW = sum_w(IN_W, OUT_W);
   localparam int unsigned CW = cnt_w(IN_W);
   localparam logic [VW-1:0]    LAST_VEC = '1;
   localparam logic [OUT_W-1:0] ET_V     = OUT_W'(ET);

   logic [1:0]              state;
   logic [31:0]             drain_cnt;
   logic                    run_v;
   logic                    d_valid;
   logic [VW-1:0]           d_vec;
   logic [OUT_W-1:0]        dout_q;
   logic [OUT_W-1:0]        exact;
   logic signed [OUT_W:0]   diff;
   logic [OUT_W-1:0]        err;
   logic                    viol;
   logic [CW-1:0]           viol_nxt;
   logic                    accept;

   assign run_v  = (state == ST_RUN);
   assign busy   = (state == ST_RUN) || (state == ST_DRAIN);
   assign done   = (state == ST_DONE);
   assign accept = (state == ST_IDLE) && start;

   apx_mon_delay #(.DEPTH(DUT_LAT + 1), .W(VW)) u_dly (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (run_v),
      .in_data   (dut_in),
      .out_valid (d_valid),
      .out_data  (d_vec)
   );

   // Captured on the same edge as the last delay stage, so dout_q pairs with d_vec.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dout_q <= '0;
      else        dout_q <= dut_out;
   end

   always_comb begin
      exact    = OUT_W'(exact_sum(32'(d_vec), IN_W));
      diff     = $signed({1'b0, dout_q}) - $signed({1'b0, exact});
      err      = diff[OUT_W] ? OUT_W'(-diff) : diff[OUT_W-1:0];
      viol     = (err > ET_V);
      viol_nxt = viol_cnt + CW'(d_valid && viol);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         dut_in    <= '0;
         drain_cnt <= '0;
         pass      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state  <= ST_RUN;
                  dut_in <= '0;
                  pass   <= 1'b0;
               end
            end
            ST_RUN: begin
               if (dut_in == LAST_VEC) begin
                  state     <= ST_DRAIN;
                  drain_cnt <= '0;
               end else begin
                  dut_in <= dut_in + 1'b1;
               end
            end
            ST_DRAIN: begin
               // The final accumulation lands on this same edge, hence viol_nxt.
               if (drain_cnt == DUT_LAT) begin
                  state <= ST_DONE;
                  pass  <= (viol_nxt == '0);
               end else begin
                  drain_cnt <= drain_cnt + 32'd1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         max_err          <= '0;
         err_sum          <= '0;
         viol_cnt         <= '0;
         first_viol_vec   <= '0;
         first_viol_valid <= 1'b0;
      end else if (accept) begin
         max_err          <= '0;
         err_sum          <= '0;
         viol_cnt         <= '0;
         first_viol_vec   <= '0;
         first_viol_valid <= 1'b0;
      end else if (d_valid) begin
         if (err > max_err) max_err <= err;
         err_sum  <= err_sum + SW'(err);
         viol_cnt <= viol_nxt;
         if (viol && !first_viol_valid) begin
            first_viol_vec   <= d_vec;
            first_viol_valid <= 1'b1;
         end
      end
   end

`ifdef APXMON_BITFLIP_EN
   logic [OUT_W-1:0][CW-1:0] flip_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flip_cnt <= '0;
      end else if (accept) begin
         flip_cnt <= '0;
      end else if (d_valid) begin
         for (int unsigned i = 0; i < OUT_W; i++) begin
            if (dout_q[i] != exact[i]) flip_cnt[i] <= flip_cnt[i] + 1'b1;
         end
      end
   end

   assign bit_flip_cnt = flip_cnt;
`endif

endmodule

// File: doc/apx_adder_err_monitor.md
Name: apx_adder_err_monitor

Overview:
- Sequential consumer and evaluator for the generated approximate adder netlists.
- Drives every input combination of an n-bit adder under test (AUT) and samples its outputs.
- Compares each sample against the exact sum and accumulates error metrics against the error threshold.
- Sits in the simulation/FPGA evaluation harness between the stimulus controller and the exported approximate adder.

Parameters:
- IN_W, 2, bits per operand; AUT has 2*IN_W inputs.
- OUT_W, IN_W+1, AUT output width.
- ET, 5, error threshold; a violation is abs error > ET.
- DUT_LAT, 0, AUT latency in cycles from dut_in to dut_out (0 = combinational).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a sweep.
- dut_in  out  2*IN_W  registered AUT stimulus; bits [IN_W-1:0] = operand a (in0 LSB), [2*IN_W-1:IN_W] = operand b.
- dut_out  in  OUT_W  AUT result (out0 LSB).
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse; results valid from this cycle on.
- pass  out  1  1 when viol_cnt == 0 at done; held until next start.
- max_err  out  OUT_W  worst abs error seen.
- err_sum  out  OUT_W+2*IN_W  sum of abs errors (no overflow possible).
- viol_cnt  out  2*IN_W+1  count of vectors with error > ET.
- first_viol_vec  out  2*IN_W  first violating stimulus.
- first_viol_valid  out  1  first_viol_vec meaningful.

Behaviour:
- Reset (async, rst_n=0): state IDLE; every output 0, including dut_in; pipeline valid bits cleared. Reset mid-sweep aborts with no done pulse.
- N = 2^(2*IN_W) vectors; exact = a + b, zero-extended to OUT_W.
- FSM:
  - IDLE: on start, clear all metrics, dut_in=0, go RUN. busy=1 from the next cycle.
  - RUN: dut_in increments each cycle. After the cycle presenting N-1, go DRAIN. dut_in holds N-1.
  - DRAIN: lasts DUT_LAT+1 cycles to flush the compare pipeline, then go DONE.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- start outside IDLE is ignored.
- Compare alignment: a stimulus-delay line of DUT_LAT+1 registers carries vector and valid. dut_out is sampled when the delayed valid is set. abs error = |dut_out - exact|, computed in OUT_W+1 bits signed and fitting OUT_W.
- Accumulation, one cycle after sample:
  - max_err = max(max_err, err).
  - err_sum += err.
  - If err > ET: viol_cnt++; if !first_viol_valid, latch first_viol_vec and set first_viol_valid.
- done asserts exactly N+DUT_LAT+2 cycles after the cycle start is sampled.
- Metric outputs update during the sweep. They are final and stable from done until the next accepted start.
- pass is updated only on the DONE cycle.

Optional Feature:
- APXMON_BITFLIP_EN defined: adds output bit_flip_cnt [OUT_W*(2*IN_W+1)-1:0]. It holds one counter per output bit, incremented when dut_out[i] != exact[i]; cleared on start and reset; final at done.
- Undefined: port and counters absent; all other behaviour identical.

Decomposition:
- Package apx_mon_pkg: state enum (IDLE, RUN, DRAIN, DONE), width localparam functions (vec width, sum width, count width), exact-sum function.
- One natural sub-module, apx_mon_delay: parameterised valid+data shift line of depth DUT_LAT+1, reused for stimulus alignment.

Test Plan:
- Exact adder model, IN_W=2, DUT_LAT=0, start at cycle 0: done at cycle 18; max_err=0, err_sum=0, viol_cnt=0, pass=1, first_viol_valid=0.
- dut_out tied 0, ET=5: max_err=6, err_sum=48, viol_cnt=1, first_viol_vec=4'b1111, pass=0.
- dut_out tied 3'b111, ET=5: max_err=7, err_sum=64, viol_cnt=3, first_viol_vec=4'b0000.
- Exact model behind 2 pipeline registers, DUT_LAT=2: done at cycle 20, all metrics 0. Same DUT with DUT_LAT=0 gives nonzero err_sum (alignment check).
- start pulsed again mid-RUN -> ignored, results as in the first case. rst_n low at cycle 8 -> all outputs 0 immediately, no done. A new start afterward completes normally.
- APXMON_BITFLIP_EN with dut_out tied 0: per-bit flip counts equal the popcount of each exact-sum bit over 16 vectors: bit0=8, bit1=8, bit2=6.
